taxi_eth_mac_stat_cnt: RTL and testbench
========================================

Name: taxi_eth_mac_stat_cnt

Overview:
Multi-channel statistics collector for the 1G MAC+FIFO wrappers, running in the logic clock domain. It takes single-cycle status pulses that are already synchronised to logic_clk from CH_CNT MAC instances, plus each channel's 2-bit link_speed. It keeps per-event and per-link-change counters, readable through a valid/ready request/response port with optional clear-on-read. It replaces ad-hoc per-port status counting in the top level and generalises it in channel count, event count and counter width.

Parameters:
CH_CNT, 4, number of MAC channels (1..16)
EVT_CNT, 10, status pulse inputs per channel (1..32)
CNT_W, 32, counter width in bits (8..64)
SATURATE, 1'b1, 1 = counters stick at all-ones; 0 = counters wrap and set a sticky wrap flag
ADDR_W, $clog2(CH_CNT*(EVT_CNT+1)), read address width (derived, do not override)

Ports:
clk  in  1  logic clock
rst_n  in  1  asynchronous active-low reset
evt  in  CH_CNT*EVT_CNT  status pulses; bit ch*EVT_CNT+e is event e of channel ch
link_speed  in  CH_CNT*2  per-channel link speed, already synchronised
req_valid  in  1  read request valid
req_ready  out  1  read request ready
req_addr  in  ADDR_W  counter index = ch*(EVT_CNT+1)+e; e==EVT_CNT selects the link-change counter
req_clr  in  1  clear the addressed counter after it is read
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_data  out  CNT_W  counter value
rsp_wrap  out  1  wrap flag of that counter (always 0 when SATURATE=1)
rsp_err  out  1  address out of range
clr_all  in  1  synchronous clear of all counters and flags

Behaviour:
- Reset (rst_n low, asynchronous): all counters and wrap flags 0; link_speed shadow registers 2'b10; req_ready 0; rsp_valid 0; rsp_data 0; rsp_wrap 0; rsp_err 0; FSM in IDLE. req_ready rises the first clk edge after rst_n deasserts.
- Event counting: each evt bit high on a clk edge adds 1 to its counter on that edge. All counters update in parallel, with no lost events at any rate, including evt held high continuously.
- Link-change counter: per channel, compare link_speed with its shadow register. On mismatch, increment the counter and update the shadow on the same edge. There is no increment on the first edge after reset if the speed equals 2'b10.
- Width: counter + 1 at CNT_W bits. SATURATE=1: all-ones stays all-ones. SATURATE=0: all-ones goes to 0 and the wrap flag is set (sticky).
- FSM IDLE: req_ready=1. On req_valid && req_ready, capture the counter value, wrap flag and err into the response registers. rsp_valid=1 on the next cycle. Go to RESP.
- FSM RESP: req_ready=0. rsp_* held stable while rsp_valid && !rsp_ready. On rsp_ready, return to IDLE, so at most one request is accepted every 2 cycles.
- Read latency: request accept edge to rsp_valid is 1 cycle. The returned value is the counter state before any increment on the accept edge.
- Clear-on-read: applied on the accept edge. If the addressed event fires on that same edge, the counter becomes 1 and the flag 0; otherwise both become 0. No event is lost or double-counted.
- Out-of-range address (>= CH_CNT*(EVT_CNT+1)): rsp_data=0, rsp_wrap=0, rsp_err=1. req_clr is ignored.
- clr_all: all counters and flags go to 0 on that edge and events on that edge are discarded. The response registers and FSM are unaffected. clr_all together with a request: the response carries the pre-clear value.
- rst_n mid-transaction: rsp_valid drops immediately and the pending response is discarded.

Optional Feature:
TAXI_STAT_SNAPSHOT_EN: adds input snap (1 bit) and a shadow copy of every counter and flag. A snap pulse copies all live values atomically on one edge. Reads return shadow values; req_clr then clears the live counter on the accept edge, but only if snap is not high on that edge. clr_all clears both live and shadow. Without the macro there is no snap port and no shadow storage, and reads return live values.

Test Plan:
- Reset, then read index 0 -> rsp_valid 1 cycle after accept; rsp_data=0, rsp_err=0. After reset, req_ready=1.
- CH_CNT=4, EVT_CNT=10: hold evt bit 23 (ch2, e3) high 100 cycles, then read addr 2*11+3=25 -> rsp_data=100.
- CNT_W=8, SATURATE=1: 300 pulses -> 255, rsp_wrap=0. SATURATE=0: 300 pulses -> 44, rsp_wrap=1.
- Pulse the event on the same edge as a req_clr accept at count 7 -> rsp_data=7; next read returns 1.
- Change ch1 link_speed 10->01->00 -> read addr 21 returns 2. Read addr 44 -> rsp_err=1, rsp_data=0.
- Hold rsp_ready low 5 cycles while events keep arriving -> rsp_data stays constant and req_ready=0; clr_all during the stall -> the held response is unchanged and the next read returns 0.

Source files
------------

// File: rtl/taxi_eth_mac_stat_cnt_if.sv
// Read request/response bundle for the MAC statistics counter block.
// master = reader (requests, consumes responses), slave = counter block.
interface taxi_eth_mac_stat_cnt_if #(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_clr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [CNT_W-1:0]  rsp_data;
    logic              rsp_wrap;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, req_clr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_wrap, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_clr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_wrap, rsp_err
    );
endinterface

// File: rtl/taxi_eth_mac_stat_cnt.sv
// Multi-channel MAC event / link-change counters with a valid/ready read port.
// Optional TAXI_STAT_SNAPSHOT_EN adds a snap input and shadow copies that reads return.
module taxi_eth_mac_stat_cnt #(
    parameter int unsigned CH_CNT   = 4,
    parameter int unsigned EVT_CNT  = 10,
    parameter int unsigned CNT_W    = 32,
    parameter bit          SATURATE = 1'b1,
    parameter int unsigned ADDR_W   = $clog2(CH_CNT*(EVT_CNT+1))
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CH_CNT*EVT_CNT-1:0] evt,
    input  logic [CH_CNT*2-1:0]       link_speed,
`ifdef TAXI_STAT_SNAPSHOT_EN
    input  logic                      snap,
`endif
    input  logic                      clr_all,
    taxi_eth_mac_stat_cnt_if.slave    bus
);

    localparam int unsigned N = CH_CNT * (EVT_CNT + 1);

    typedef enum logic {StIdle, StResp} state_e;

    state_e            state_q, state_d;
    logic              rdy_en_q;
    logic [1:0]        speed_q [CH_CNT];
    logic [CNT_W-1:0]  cnt_q [N];
    logic [CNT_W-1:0]  cnt_d [N];
    logic [N-1:0]      wrap_q, wrap_d;
    logic [N-1:0]      inc;
    logic [CNT_W-1:0]  rd_cnt;
    logic              rd_wrap;
    logic              in_range, accept, clr_live;
    logic [CNT_W-1:0]  rsp_data_q;
    logic              rsp_wrap_q, rsp_err_q;

`ifdef TAXI_STAT_SNAPSHOT_EN
    logic [CNT_W-1:0]  snap_cnt_q [N];
    logic [N-1:0]      snap_wrap_q;
`endif

    assign in_range = 32'(bus.req_addr) < N;
    assign accept   = bus.req_valid && bus.req_ready;
`ifdef TAXI_STAT_SNAPSHOT_EN
    assign clr_live = accept && bus.req_clr && in_range && !snap;
`else
    assign clr_live = accept && bus.req_clr && in_range;
`endif

    // Slot EVT_CNT of each channel is the link-change counter.
    always_comb begin
        inc = '0;
        for (int unsigned ch = 0; ch < CH_CNT; ch++) begin
            for (int unsigned e = 0; e < EVT_CNT; e++) begin
                inc[ch*(EVT_CNT+1)+e] = evt[ch*EVT_CNT+e];
            end
            inc[ch*(EVT_CNT+1)+EVT_CNT] = link_speed[ch*2+:2] != speed_q[ch];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            cnt_d[i]  = cnt_q[i];
            wrap_d[i] = wrap_q[i];
            if (inc[i]) begin
                if (&cnt_q[i]) begin
                    if (!SATURATE) begin
                        cnt_d[i]  = '0;
                        wrap_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            // Clear-on-read keeps an event landing on the accept edge.
            if (clr_live && (ADDR_W'(i) == bus.req_addr)) begin
                cnt_d[i]  = CNT_W'(inc[i]);
                wrap_d[i] = 1'b0;
            end
            if (clr_all) begin
                cnt_d[i]  = '0;
                wrap_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
            for (int unsigned ch = 0; ch < CH_CNT; ch++) speed_q[ch] <= 2'b10;
            wrap_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
            for (int unsigned ch = 0; ch < CH_CNT; ch++) speed_q[ch] <= link_speed[ch*2+:2];
            wrap_q <= wrap_d;
        end
    end

`ifdef TAXI_STAT_SNAPSHOT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) snap_cnt_q[i] <= '0;
            snap_wrap_q <= '0;
        end else if (clr_all) begin
            for (int unsigned i = 0; i < N; i++) snap_cnt_q[i] <= '0;
            snap_wrap_q <= '0;
        end else if (snap) begin
            for (int unsigned i = 0; i < N; i++) snap_cnt_q[i] <= cnt_q[i];
            snap_wrap_q <= wrap_q;
        end
    end
`endif

    always_comb begin
        rd_cnt  = '0;
        rd_wrap = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (ADDR_W'(i) == bus.req_addr) begin
`ifdef TAXI_STAT_SNAPSHOT_EN
                rd_cnt  = snap_cnt_q[i];
                rd_wrap = snap_wrap_q[i];
`else
                rd_cnt  = cnt_q[i];
                rd_wrap = wrap_q[i];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StResp;
            StResp: if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // rdy_en_q holds ready low until the first edge after reset release.
    always_comb begin
        bus.req_ready = (state_q == StIdle) && rdy_en_q;
        bus.rsp_valid = (state_q == StResp);
        bus.rsp_data  = rsp_data_q;
        bus.rsp_wrap  = rsp_wrap_q;
        bus.rsp_err   = rsp_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_wrap_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else if (accept) begin
            rsp_data_q <= in_range ? rd_cnt : '0;
            rsp_wrap_q <= in_range && rd_wrap;
            rsp_err_q  <= !in_range;
        end
    end

endmodule

// File: tb/tb_taxi_eth_mac_stat_cnt.sv
// Directed bench: 4x10 32-bit saturating DUT plus two 1x1 8-bit DUTs (saturate / wrap).
module tb_taxi_eth_mac_stat_cnt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [39:0] evt;
    logic [7:0]  ls;
    logic        clr_all;
    logic [0:0]  small_evt;
    logic [1:0]  small_ls;
    logic        small_clr;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    taxi_eth_mac_stat_cnt_if #(.CNT_W(32), .ADDR_W(6)) m_if ();
    taxi_eth_mac_stat_cnt_if #(.CNT_W(8),  .ADDR_W(1)) s_if ();
    taxi_eth_mac_stat_cnt_if #(.CNT_W(8),  .ADDR_W(1)) w_if ();

    taxi_eth_mac_stat_cnt #(.CH_CNT(4), .EVT_CNT(10), .CNT_W(32), .SATURATE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .evt(evt), .link_speed(ls), .clr_all(clr_all), .bus(m_if)
    );
    taxi_eth_mac_stat_cnt #(.CH_CNT(1), .EVT_CNT(1), .CNT_W(8), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .evt(small_evt), .link_speed(small_ls), .clr_all(small_clr),
        .bus(s_if)
    );
    taxi_eth_mac_stat_cnt #(.CH_CNT(1), .EVT_CNT(1), .CNT_W(8), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .evt(small_evt), .link_speed(small_ls), .clr_all(small_clr),
        .bus(w_if)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // sel: 0 main, 1 saturating 8-bit, 2 wrapping 8-bit. pbit>=0 pulses that main evt bit
    // on the accept edge; got=1 only if rsp_valid is high one cycle after the accept.
    task automatic do_read(input int sel, input int addr, input bit clr, input int pbit,
                           input bit cla, output logic [31:0] data, output logic wrap,
                           output logic err, output bit got);
        logic rdy;
        logic [5:0] a6;
        got  = 1'b0;
        data = 'x;
        wrap = 1'bx;
        err  = 1'bx;
        a6   = 6'(addr);
        for (int t = 0; t < 20; t++) begin
            rdy = (sel == 0) ? m_if.req_ready : (sel == 1) ? s_if.req_ready : w_if.req_ready;
            if (rdy) break;
            step();
        end
        if (!rdy) return;
        m_if.req_valid = (sel == 0);
        s_if.req_valid = (sel == 1);
        w_if.req_valid = (sel == 2);
        m_if.req_addr  = a6;
        s_if.req_addr  = a6[0];
        w_if.req_addr  = a6[0];
        m_if.req_clr   = clr;
        s_if.req_clr   = clr;
        w_if.req_clr   = clr;
        if (pbit >= 0) evt[pbit] = 1'b1;
        clr_all = cla;
        step();
        m_if.req_valid = 1'b0;
        s_if.req_valid = 1'b0;
        w_if.req_valid = 1'b0;
        if (pbit >= 0) evt[pbit] = 1'b0;
        clr_all = 1'b0;
        case (sel)
            0: begin got = m_if.rsp_valid; data = m_if.rsp_data;
                     wrap = m_if.rsp_wrap; err = m_if.rsp_err; end
            1: begin got = s_if.rsp_valid; data = {24'd0, s_if.rsp_data};
                     wrap = s_if.rsp_wrap; err = s_if.rsp_err; end
            default: begin got = w_if.rsp_valid; data = {24'd0, w_if.rsp_data};
                           wrap = w_if.rsp_wrap; err = w_if.rsp_err; end
        endcase
        m_if.rsp_ready = 1'b1;
        s_if.rsp_ready = 1'b1;
        w_if.rsp_ready = 1'b1;
        step();
        m_if.rsp_ready = 1'b0;
        s_if.rsp_ready = 1'b0;
        w_if.rsp_ready = 1'b0;
    endtask

    logic [31:0] d;
    logic        w, e;
    bit          g;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if (m_if.req_ready !== 1'b0 || m_if.rsp_valid !== 1'b0 || m_if.rsp_data !== 32'd0)
            $display("FAIL reset_state: ready=%b valid=%b data=%0d required 0/0/0",
                     m_if.req_ready, m_if.rsp_valid, m_if.rsp_data);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
        chk_cnt++;
        if (m_if.req_ready !== 1'b1)
            $display("FAIL ready_after_reset: got %b required 1", m_if.req_ready);
        else pass_cnt++;
        do_read(0, 0, 0, -1, 0, d, w, e, g);
        chk_cnt++;
        if (g !== 1'b1 || d !== 32'd0 || e !== 1'b0)
            $display("FAIL reset_read0: valid=%b data=%0d err=%b required 1/0/0", g, d, e);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        evt[23] = 1'b1;
        repeat (100) step();
        evt[23] = 1'b0;
        do_read(0, 25, 0, -1, 0, d, w, e, g);
        chk_cnt++;
        if (g !== 1'b1 || d !== 32'd100 || e !== 1'b0 || w !== 1'b0)
            $display("FAIL hold_100: valid=%b data=%0d err=%b wrap=%b required 1/100/0/0",
                     g, d, e, w);
        else pass_cnt++;
    endtask

    task automatic test_width();
        small_evt = 1'b1;
        repeat (300) step();
        small_evt = 1'b0;
        do_read(1, 0, 0, -1, 0, d, w, e, g);
        chk_cnt++;
        if (g !== 1'b1 || d !== 32'd255 || w !== 1'b0)
            $display("FAIL saturate: valid=%b data=%0d wrap=%b required 1/255/0", g, d, w);
        else pass_cnt++;
        do_read(2, 0, 0, -1, 0, d, w, e, g);
        chk_cnt++;
        if (g !== 1'b1 || d !== 32'd44 || w !== 1'b1)
            $display("FAIL wrap: valid=%b data=%0d wrap=%b required 1/44/1", g, d, w);
        else pass_cnt++;
        do_read(2, 1, 0, -1, 0, d, w, e, g);
        chk_cnt++;
        if (g !== 1'b1 || d !== 32'd0 || e !== 1'b0)
            $display("FAIL small_link: valid=%b data=%0d err=%b required 1/0/0", g, d, e);
        else pass_cnt++;
    endtask

    task automatic test_clr_on_read();
        evt[5] = 1'b1;
        repeat (7) step();
        evt[5] = 1'b0;
        do_read(0, 5, 1, 5, 0, d, w, e, g);
        chk_cnt++;
        if (g !== 1'b1 || d !== 32'd7)
            $display("FAIL clr_read_value: valid=%b data=%0d required 1/7", g, d);
        else pass_cnt++;
        do_read(0, 5, 0, -1, 0, d, w, e, g);
        chk_cnt++;
        if (g !== 1'b1 || d !== 32'd1)
            $display("FAIL clr_read_same_edge_evt: valid=%b data=%0d required 1/1", g, d);
        else pass_cnt++;
    endtask

    task automatic test_clr_all_req();
        evt[0] = 1'b1;
        repeat (3) step();
        evt[0] = 1'b0;
        do_read(0, 0, 0, -1, 1, d, w, e, g);
        chk_cnt++;
        if (g !== 1'b1 || d !== 32'd3)
            $display("FAIL clr_all_req_preclear: valid=%b data=%0d required 1/3", g, d);
        else pass_cnt++;
        do_read(0, 0, 0, -1, 0, d, w, e, g);
        chk_cnt++;
        if (g !== 1'b1 || d !== 32'd0)
            $display("FAIL clr_all_req_after: valid=%b data=%0d required 1/0", g, d);
        else pass_cnt++;
    endtask

    task automatic test_link();
        ls[3:2] = 2'b01;
        step();
        ls[3:2] = 2'b00;
        step();
        do_read(0, 21, 0, -1, 0, d, w, e, g);
        chk_cnt++;
        if (g !== 1'b1 || d !== 32'd2 || e !== 1'b0)
            $display("FAIL link_ch1: valid=%b data=%0d err=%b required 1/2/0", g, d, e);
        else pass_cnt++;
        do_read(0, 10, 0, -1, 0, d, w, e, g);
        chk_cnt++;
        if (g !== 1'b1 || d !== 32'd0)
            $display("FAIL link_ch0: valid=%b data=%0d required 1/0", g, d);
        else pass_cnt++;
        do_read(0, 44, 1, -1, 0, d, w, e, g);
        chk_cnt++;
        if (g !== 1'b1 || d !== 32'd0 || e !== 1'b1 || w !== 1'b0)
            $display("FAIL oor_44: valid=%b data=%0d err=%b wrap=%b required 1/0/1/0",
                     g, d, e, w);
        else pass_cnt++;
        do_read(0, 43, 0, -1, 0, d, w, e, g);
        chk_cnt++;
        if (g !== 1'b1 || d !== 32'd0 || e !== 1'b0)
            $display("FAIL last_in_range_43: valid=%b data=%0d err=%b required 1/0/0", g, d, e);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        evt[30] = 1'b1;
        repeat (10) step();
        m_if.req_addr  = 6'd33;
        m_if.req_clr   = 1'b0;
        m_if.req_valid = 1'b1;
        step();
        m_if.req_valid = 1'b0;
        chk_cnt++;
        if (m_if.rsp_valid !== 1'b1 || m_if.rsp_data !== 32'd10)
            $display("FAIL stall_first: valid=%b data=%0d required 1/10",
                     m_if.rsp_valid, m_if.rsp_data);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                clr_all = 1'b1;
                evt[30] = 1'b0;
            end
            step();
            clr_all = 1'b0;
            chk_cnt++;
            if (m_if.rsp_valid !== 1'b1 || m_if.rsp_data !== 32'd10 || m_if.req_ready !== 1'b0)
                $display("FAIL stall_hold_%0d: valid=%b data=%0d ready=%b required 1/10/0",
                         i, m_if.rsp_valid, m_if.rsp_data, m_if.req_ready);
            else pass_cnt++;
        end
        m_if.rsp_ready = 1'b1;
        step();
        m_if.rsp_ready = 1'b0;
        do_read(0, 33, 0, -1, 0, d, w, e, g);
        chk_cnt++;
        if (g !== 1'b1 || d !== 32'd0)
            $display("FAIL stall_after_clr_all: valid=%b data=%0d required 1/0", g, d);
        else pass_cnt++;
        do_read(0, 25, 0, -1, 0, d, w, e, g);
        chk_cnt++;
        if (g !== 1'b1 || d !== 32'd0)
            $display("FAIL clr_all_other: valid=%b data=%0d required 1/0", g, d);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        ls = {4{2'b10}};
        step();
        evt[1] = 1'b1;
        step();
        evt[1] = 1'b0;
        m_if.req_addr  = 6'd1;
        m_if.req_valid = 1'b1;
        step();
        m_if.req_valid = 1'b0;
        chk_cnt++;
        if (m_if.rsp_valid !== 1'b1 || m_if.rsp_data !== 32'd1)
            $display("FAIL mid_pre: valid=%b data=%0d required 1/1",
                     m_if.rsp_valid, m_if.rsp_data);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (m_if.rsp_valid !== 1'b0 || m_if.rsp_data !== 32'd0 || m_if.req_ready !== 1'b0)
            $display("FAIL mid_reset: valid=%b data=%0d ready=%b required 0/0/0",
                     m_if.rsp_valid, m_if.rsp_data, m_if.req_ready);
        else pass_cnt++;
        #2 rst_n = 1'b1;
        step();
        do_read(0, 1, 0, -1, 0, d, w, e, g);
        chk_cnt++;
        if (g !== 1'b1 || d !== 32'd0)
            $display("FAIL mid_after: valid=%b data=%0d required 1/0", g, d);
        else pass_cnt++;
    endtask

    initial begin
        evt            = '0;
        ls             = {4{2'b10}};
        clr_all        = 1'b0;
        small_evt      = '0;
        small_ls       = 2'b10;
        small_clr      = 1'b0;
        m_if.req_valid = 1'b0;
        m_if.req_addr  = '0;
        m_if.req_clr   = 1'b0;
        m_if.rsp_ready = 1'b0;
        s_if.req_valid = 1'b0;
        s_if.req_addr  = '0;
        s_if.req_clr   = 1'b0;
        s_if.rsp_ready = 1'b0;
        w_if.req_valid = 1'b0;
        w_if.req_addr  = '0;
        w_if.req_clr   = 1'b0;
        w_if.rsp_ready = 1'b0;
        test_reset();
        test_hold();
        test_width();
        test_clr_on_read();
        test_clr_all_req();
        test_link();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
